// File: rtl/ioc_arbiter.sv
// ioc_arbiter: round-robin arbiter bridging two requesters onto a shared IOC register bus.
// Every bus-facing output comes straight from a flop; the next-state logic precomputes it.
module ioc_arbiter #(
    parameter int RD_LAT  = 2,
    parameter int NUM_MOD = 4
) (
    input  logic               i_sys_clk,
    input  logic               i_rst,
    input  logic               i_req_a,
    input  logic               i_req_b,
    input  logic               i_rnw_a,
    input  logic               i_rnw_b,
    input  logic [7:0]         i_addr_a,
    input  logic [7:0]         i_addr_b,
    input  logic [7:0]         i_wdata_a,
    input  logic [7:0]         i_wdata_b,
    output logic               o_ack_a,
    output logic               o_ack_b,
    output logic [7:0]         o_rdata,
    output logic               o_err,
    output logic [4:0]         o_ioc,
    output logic [7:0]         o_data_out,
    input  logic [7:0]         i_data_in,
    output logic [NUM_MOD-1:0] o_cs,
    output logic               o_fetch_cmd,
    output logic               o_load_cmd
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

    state_t state_q, state_d;
    logic gnt_b_q, gnt_b_d, last_b_q, last_b_d, rnw_q, rnw_d, inv_q, inv_d;
    logic [2:0] cnt_q, cnt_d;
    logic [NUM_MOD-1:0] cs_q, cs_d;
    logic [4:0] ioc_q, ioc_d;
    logic [7:0] dout_q, dout_d, rdata_q, rdata_d;
    logic fetch_q, fetch_d, load_q, load_d, ack_a_q, ack_a_d, ack_b_q, ack_b_d, err_q, err_d;
    logic grant_b, rnw_in, valid_in;
    logic [7:0] addr_in, wdata_in;

    // B wins only if A is idle or A was served last
    assign grant_b  = i_req_b & (~i_req_a | ~last_b_q);
    assign rnw_in   = grant_b ? i_rnw_b : i_rnw_a;
    assign addr_in  = grant_b ? i_addr_b : i_addr_a;
    assign wdata_in = grant_b ? i_wdata_b : i_wdata_a;
    assign valid_in = int'(addr_in[7:5]) < NUM_MOD;

    always_comb begin
        state_d = state_q;
        gnt_b_d = gnt_b_q;
        last_b_d = last_b_q;
        rnw_d = rnw_q;
        inv_d = inv_q;
        cnt_d = cnt_q;
        cs_d = '0;
        ioc_d = '0;
        dout_d = '0;
        fetch_d = 1'b0;
        load_d = 1'b0;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        err_d = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (i_req_a | i_req_b) begin
                state_d = CMD;
                gnt_b_d = grant_b;
                last_b_d = grant_b;
                rnw_d = rnw_in;
                inv_d = ~valid_in;
                if (valid_in) begin
                    cs_d = NUM_MOD'(1) << addr_in[7:5];
                    ioc_d = addr_in[4:0];
                    dout_d = wdata_in;
                    fetch_d = rnw_in;
                    load_d = ~rnw_in;
                end
            end
            // an invalid select spends this cycle with the bus idle, then errors out
            CMD: if (!inv_q && rnw_q) begin
                state_d = WAIT;
                cnt_d = 3'(RD_LAT - 1);
                cs_d = cs_q;
                ioc_d = ioc_q;
            end else begin
                state_d = DONE;
                ack_a_d = ~gnt_b_q;
                ack_b_d = gnt_b_q;
                err_d = inv_q;
                rdata_d = inv_q ? 8'hFF : rdata_q;
            end
            WAIT: if (cnt_q == 3'd0) begin
                state_d = DONE;
                ack_a_d = ~gnt_b_q;
                ack_b_d = gnt_b_q;
                rdata_d = i_data_in;
            end else begin
                cnt_d = cnt_q - 3'd1;
                cs_d = cs_q;
                ioc_d = ioc_q;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_b_q <= 1'b0;
            last_b_q <= 1'b1;
            rnw_q <= 1'b0;
            inv_q <= 1'b0;
            cnt_q <= '0;
            cs_q <= '0;
            ioc_q <= '0;
            dout_q <= '0;
            fetch_q <= 1'b0;
            load_q <= 1'b0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            err_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_b_q <= gnt_b_d;
            last_b_q <= last_b_d;
            rnw_q <= rnw_d;
            inv_q <= inv_d;
            cnt_q <= cnt_d;
            cs_q <= cs_d;
            ioc_q <= ioc_d;
            dout_q <= dout_d;
            fetch_q <= fetch_d;
            load_q <= load_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            err_q <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_ack_a = ack_a_q;
    assign o_ack_b = ack_b_q;
    assign o_rdata = rdata_q;
    assign o_err = err_q;
    assign o_ioc = ioc_q;
    assign o_data_out = dout_q;
    assign o_cs = cs_q;
    assign o_fetch_cmd = fetch_q;
    assign o_load_cmd = load_q;
endmodule

// File: tb/tb_ioc_arbiter.sv
// tb_ioc_arbiter: directed checks of ioc_arbiter timing, arbitration, errors and reset.
module tb_ioc_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic req_a = 0, req_b = 0, rnw_a = 0, rnw_b = 0;
    logic [7:0] addr_a = 0, addr_b = 0, wdata_a = 0, wdata_b = 0, data_in = 0;
    logic ack_a, ack_b, err, fetch, load;
    logic [7:0] rdata, dout;
    logic [4:0] ioc;
    logic [3:0] cs;
    int total = 0, passed = 0;

    ioc_arbiter #(.RD_LAT(2), .NUM_MOD(4)) dut (
        .i_sys_clk(clk), .i_rst(rst),
        .i_req_a(req_a), .i_req_b(req_b), .i_rnw_a(rnw_a), .i_rnw_b(rnw_b),
        .i_addr_a(addr_a), .i_addr_b(addr_b), .i_wdata_a(wdata_a), .i_wdata_b(wdata_b),
        .o_ack_a(ack_a), .o_ack_b(ack_b), .o_rdata(rdata), .o_err(err),
        .o_ioc(ioc), .o_data_out(dout), .i_data_in(data_in), .o_cs(cs),
        .o_fetch_cmd(fetch), .o_load_cmd(load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // packs every output so one comparison covers the whole bus
    function automatic logic [31:0] outs();
        return {ack_a, ack_b, err, fetch, load, cs, ioc, dout, rdata};
    endfunction

    initial begin
        step();
        chk("reset_outputs", outs(), 32'h0);
        step();
        rst = 1'b0;

        req_a = 1; rnw_a = 0; addr_a = 8'h04; wdata_a = 8'h01;
        step();
        chk("wr_cmd_cs", cs, 4'b0001);
        chk("wr_cmd_load", {load, fetch}, 2'b10);
        chk("wr_cmd_ioc", ioc, 5'h04);
        chk("wr_cmd_dout", dout, 8'h01);
        chk("wr_cmd_noack", ack_a, 1'b0);
        step();
        chk("wr_done_ack", {ack_a, ack_b, err}, 3'b100);
        chk("wr_done_bus", {cs, load, fetch}, 6'b0);
        req_a = 0;
        step();
        chk("wr_idle_ack", ack_a, 1'b0);

        req_b = 1; rnw_b = 1; addr_b = 8'h22; data_in = 8'h5A;
        step();
        chk("rd_cmd", {cs, fetch, load, ioc}, {4'b0010, 1'b1, 1'b0, 5'h02});
        step();
        chk("rd_wait1", {cs, fetch, load, ack_b}, {4'b0010, 3'b000});
        step();
        chk("rd_wait2", {cs, fetch, load, ack_b}, {4'b0010, 3'b000});
        step();
        chk("rd_done_ack", {ack_b, ack_a, err, cs}, {3'b100, 4'b0000});
        chk("rd_done_data", rdata, 8'h5A);
        req_b = 0;
        data_in = 8'h00;
        step();

        req_a = 1; rnw_a = 1; addr_a = 8'hA0;
        step();
        chk("inv_cmd_quiet", {cs, fetch, load, ack_a, err}, 9'b0);
        step();
        chk("inv_done", {ack_a, err, cs, fetch, load}, {2'b11, 6'b0});
        chk("inv_rdata", rdata, 8'hFF);
        req_a = 0;
        step();
        chk("inv_err_pulse", {err, ack_a}, 2'b00);
        chk("rdata_hold", rdata, 8'hFF);

        rst = 1;
        #1;
        rst = 0;
        chk("reset_rdata", rdata, 8'h00);
        req_a = 1; rnw_a = 0; addr_a = 8'h01; wdata_a = 8'hA5;
        req_b = 1; rnw_b = 0; addr_b = 8'h61; wdata_b = 8'h5B;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr_cmd%0d", k), {cs, load, dout},
                (k % 2) ? {4'b1000, 1'b1, 8'h5B} : {4'b0001, 1'b1, 8'hA5});
            step();
            chk($sformatf("rr_ack%0d", k), {ack_a, ack_b, cs},
                (k % 2) ? {2'b01, 4'b0} : {2'b10, 4'b0});
            step();
            chk($sformatf("rr_gap%0d", k), {cs, ack_a, ack_b}, 6'b0);
        end
        req_a = 0; req_b = 0;
        step();

        req_a = 1; rnw_a = 1; addr_a = 8'h01; data_in = 8'h33;
        step();
        chk("rst_cmd", {cs, fetch}, 5'b00011);
        step();
        chk("rst_wait", cs, 4'b0001);
        #2;
        rst = 1;
        #1;
        chk("rst_async_clear", outs(), 32'h0);
        step();
        chk("rst_held_noack", outs(), 32'h0);
        rst = 0;
        step();
        chk("restart_cmd", {cs, fetch, ioc}, {4'b0001, 1'b1, 5'h01});
        step();
        step();
        chk("restart_noack", ack_a, 1'b0);
        step();
        chk("restart_done", {ack_a, err, rdata}, {2'b10, 8'h33});
        req_a = 0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $fatal(1, "FAIL timeout: observed no finish expected finish");
    end
endmodule
